// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the convolution datapath: default geometry and
// sample widths (also used by the line-buffer window generator and the
// max-pool stage), the accumulator width rule, and the requantise/saturate
// helper used on the final sum.
//
// Functions:
//   acc_width(dw, ww, ch, t) : full-precision accumulator width
//   sat_shift(acc, shift, ow): arithmetic right shift then clamp to a signed
//                              ow-bit range (result returned sign-extended)
package conv_pkg;

    localparam int CONV_CH    = 3;
    localparam int CONV_K     = 5;
    localparam int CONV_DW    = 12;
    localparam int CONV_WW    = 8;
    localparam int CONV_OW    = 14;
    localparam int CONV_SHIFT = 6;

    // Each product needs dw+ww bits; summing ch*t of them grows the
    // magnitude by at most clog2(ch*t) bits, so nothing can overflow.
    function automatic int acc_width(input int dw, input int ww, input int ch, input int t);
        return dw + ww + $clog2(ch * t);
    endfunction

    // Width-independent form: the caller sign-extends into 64 bits and keeps
    // the low ow bits of the result, which always fit after the clamp.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int shift,
                                                     input int ow);
        logic signed [63:0] q;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        q     = acc >>> shift;
        max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (ow - 1));
        if (q > max_v) begin
            return max_v;
        end else if (q < min_v) begin
            return min_v;
        end
        return q;
    endfunction

endpackage

// File: rtl/conv_dot_k.sv
// conv_dot_k
// One input channel of the convolution: T signed multiplies registered in
// the first stage, then the T products summed and registered in the second.
// No reset: the data path is qualified by valid tags kept in the parent.
//
// Ports:
//   clk     : clock
//   data    : T samples, DW bits each, tap 0 in the LSBs
//   weights : T weights, WW bits each, tap 0 in the LSBs
//   sum     : registered tap sum, two cycles after data is presented
module conv_dot_k
    import conv_pkg::*;
#(
    parameter int T  = CONV_K * CONV_K,
    parameter int DW = CONV_DW,
    parameter int WW = CONV_WW,
    parameter int SW = CONV_DW + CONV_WW + $clog2(CONV_K * CONV_K)
) (
    input  logic                 clk,
    input  logic [T*DW-1:0]      data,
    input  logic [T*WW-1:0]      weights,
    output logic signed [SW-1:0] sum
);

    localparam int PW = DW + WW;

    logic signed [DW-1:0] smp   [T];
    logic signed [WW-1:0] wgt   [T];
    logic signed [PW-1:0] prod_reg [T];
    logic signed [SW-1:0] sum_next;
    logic signed [SW-1:0] sum_reg;

    genvar gi;
    generate
        for (gi = 0; gi < T; gi++) begin : g_tap
            assign smp[gi] = data[gi*DW +: DW];
            assign wgt[gi] = weights[gi*WW +: WW];
        end
    endgenerate

    // Operands are sign-extended to the full product width before the
    // multiply so the product is exact.
    always_ff @(posedge clk) begin
        for (int i = 0; i < T; i++) begin
            prod_reg[i] <= PW'(smp[i]) * PW'(wgt[i]);
        end
    end

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < T; i++) begin
            sum_next = sum_next + SW'(prod_reg[i]);
        end
    end

    always_ff @(posedge clk) begin
        sum_reg <= sum_next;
    end

    assign sum = sum_reg;

endmodule

// File: rtl/conv_mac_array.sv
// conv_mac_array
// Multi-channel K x K convolution MAC. Each accepted window (CH channels of
// K*K samples) is multiplied against a runtime-loadable weight bank, summed
// over taps and channels at full precision, arithmetically shifted right by
// SHIFT and saturated to OW signed bits. Results carry a pair tag for the
// downstream 2-wide max-pool.
//
// Pipeline: products -> per-channel sums -> cross-channel sum -> output.
// A window accepted at edge n appears on the outputs after edge n+3.
//
// Build option: define CONV_RELU_EN to force negative saturated results to 0.
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   in_valid      : window present on in_data
//   in_row_start  : window starts a new output row (qualified by in_valid)
//   in_data       : CH*K*K samples, channel-major, tap 0 in the LSBs
//   w_we/w_addr/w_data : weight write (index = ch*K*K + tap)
//   out_valid     : out_data carries a new result
//   out_data      : requantised, saturated result (held between results)
//   out_pair      : 0 = first, 1 = second of a horizontal pool pair
module conv_mac_array
    import conv_pkg::*;
#(
    parameter int CH    = CONV_CH,
    parameter int K     = CONV_K,
    parameter int DW    = CONV_DW,
    parameter int WW    = CONV_WW,
    parameter int OW    = CONV_OW,
    parameter int SHIFT = CONV_SHIFT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic                        in_row_start,
    input  logic [CH*K*K*DW-1:0]        in_data,
    input  logic                        w_we,
    input  logic [$clog2(CH*K*K)-1:0]   w_addr,
    input  logic [WW-1:0]               w_data,
    output logic                        out_valid,
    output logic [OW-1:0]               out_data,
    output logic                        out_pair
);

    localparam int T    = K * K;
    localparam int NW   = CH * T;
    localparam int AW   = $clog2(NW);
    localparam int SW   = DW + WW + $clog2(T);
    localparam int ACCW = acc_width(DW, WW, CH, T);

    // Weight bank: plain registers, deliberately not reset so a reset
    // between frames keeps the loaded kernel. Windows sampled on the same
    // edge as a write see the old value.
    logic [WW-1:0] w_mem [NW];

    always_ff @(posedge clk) begin
        if (w_we && ({1'b0, w_addr} < (AW + 1)'(NW))) begin
            w_mem[w_addr] <= w_data;
        end
    end

    // Stages 1-2: one dot-product unit per channel
    logic signed [SW-1:0] ch_sum [CH];

    genvar gi, gj;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [T*WW-1:0] w_flat;
            for (gj = 0; gj < T; gj++) begin : g_w
                assign w_flat[gj*WW +: WW] = w_mem[gi*T + gj];
            end

            conv_dot_k #(
                .T  (T),
                .DW (DW),
                .WW (WW),
                .SW (SW)
            ) u_dot (
                .clk     (clk),
                .data    (in_data[gi*T*DW +: T*DW]),
                .weights (w_flat),
                .sum     (ch_sum[gi])
            );
        end
    endgenerate

    // Stage 3: cross-channel sum at full precision
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] acc_reg;

    always_comb begin
        acc_next = '0;
        for (int c = 0; c < CH; c++) begin
            acc_next = acc_next + ACCW'(ch_sum[c]);
        end
    end

    always_ff @(posedge clk) begin
        acc_reg <= acc_next;
    end

    // Requantise and saturate; only the low OW bits of the clamped value
    // are meaningful, the rest are sign copies.
    logic signed [63:0] sat_full;
    logic [OW-1:0]      res_next;
    logic               sat_unused;

    assign sat_full   = sat_shift(64'(acc_reg), SHIFT, OW);
    assign sat_unused = ^sat_full[63:OW];

    always_comb begin
        res_next = sat_full[OW-1:0];
`ifdef CONV_RELU_EN
        if (sat_full[63]) begin
            res_next = '0;
        end
`else
`endif
    end

    // Valid and row-start tags ride alongside the three data stages.
    // out_pair resets to 1 so the first result after reset is tagged 0.
    logic [2:0] vld_reg;
    logic [2:0] row_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_reg   <= '0;
            row_reg   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pair  <= 1'b1;
        end else begin
            vld_reg   <= {vld_reg[1:0], in_valid};
            row_reg   <= {row_reg[1:0], in_valid & in_row_start};
            out_valid <= vld_reg[2];
            if (vld_reg[2]) begin
                out_data <= res_next;
                out_pair <= row_reg[2] ? 1'b0 : ~out_pair;
            end
        end
    end

endmodule
